// File: rtl/serial_pkg.sv
// serial_pkg: constants and FSM encoding shared by paralelo_serie and serie_paralelo.
package serial_pkg;
    localparam int SYMBOL_BITS = 8;
    localparam logic [SYMBOL_BITS-1:0] COMMA_BC = 8'hBC;
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        DATA = 2'd2
    } link_state_t;
endpackage

// File: rtl/paralelo_serie_shifter.sv
// paralelo_serie_shifter: MSB-first symbol shift register and 8-cycle symbol counter.
module paralelo_serie_shifter
    import serial_pkg::*;
(
    input  logic                   clk_32f,
    input  logic                   reset_L,
    input  logic [SYMBOL_BITS-1:0] load_val,
    output logic                   load,
    output logic                   data_out
);
    logic [SYMBOL_BITS-1:0] sh;
    logic [2:0]             bit_idx;
    assign load     = bit_idx == 3'd7;
    assign data_out = sh[SYMBOL_BITS-1];
    // Reset parks bit_idx at 7 so the first edge after release loads a symbol.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            sh      <= '0;
            bit_idx <= 3'd7;
        end else begin
            sh      <= load ? load_val : {sh[SYMBOL_BITS-2:0], 1'b0};
            bit_idx <= load ? 3'd0 : bit_idx + 3'd1;
        end
    end
endmodule

// File: rtl/paralelo_serie.sv
// paralelo_serie: byte-to-bit transmitter with comma preamble and idle fill.
// Defining PS_BC_COUNTER_EN adds bc_counter_out, a saturating count of comma loads.
module paralelo_serie
    import serial_pkg::*;
#(
    parameter int                     SYNC_COUNT  = 4,
    parameter logic [SYMBOL_BITS-1:0] IDLE_SYMBOL = COMMA_BC
) (
    input  logic                   clk_32f,
    input  logic                   reset_L,
    input  logic [SYMBOL_BITS-1:0] data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic                   data_out,
    output logic                   active_out
`ifdef PS_BC_COUNTER_EN
    ,
    output logic [2:0]             bc_counter_out
`endif
);
    localparam logic [2:0] SYNC_LAST = 3'(SYNC_COUNT - 1);
    link_state_t state;
    logic [2:0] sync_cnt;
    logic       load, take;
    // The last preamble comma is loaded on the SYNC->IDLE edge, so its final bit already sees IDLE.
    assign ready_out = load && state != SYNC;
    assign take      = valid_in && ready_out;
    paralelo_serie_shifter u_shifter (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .load_val(take ? data_in : IDLE_SYMBOL),
        .load    (load),
        .data_out(data_out)
    );
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state      <= SYNC;
            sync_cnt   <= '0;
            active_out <= 1'b0;
        end else if (load) begin
            active_out <= take;
            sync_cnt   <= state == SYNC ? sync_cnt + 3'd1 : sync_cnt;
            state      <= state == SYNC ? (sync_cnt == SYNC_LAST ? IDLE : SYNC) : (take ? DATA : IDLE);
        end
    end
`ifdef PS_BC_COUNTER_EN
    always_ff @(posedge clk_32f) begin
        if (!reset_L)
            bc_counter_out <= '0;
        else if (load && !take && bc_counter_out != 3'd7)
            bc_counter_out <= bc_counter_out + 3'd1;
    end
`endif
endmodule

// File: tb/tb_paralelo_serie.sv
// tb_paralelo_serie: table-driven and scoreboard checks of the serial transmitter.
module tb_paralelo_serie;
    localparam logic [7:0] BC = 8'hBC;
    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready_out, data_out, active_out;
`ifdef PS_BC_COUNTER_EN
    logic [2:0] bc_counter_out;
`endif
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_sym;
        logic       exp_act;
    } vec_t;
    typedef struct {
        logic bit_v;
        logic act;
    } exp_t;
    vec_t vecs[8];
    exp_t sb[$];
    logic [7:0] w;

    paralelo_serie dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .active_out(active_out)
`ifdef PS_BC_COUNTER_EN
        ,
        .bc_counter_out(bc_counter_out)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    task automatic step();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preamble(input logic v, input logic [7:0] d);
        logic [7:0] sym = BC;
        valid_in = v;
        data_in  = d;
        reset_L  = 1'b0;
        repeat (3) begin
            step();
            chk("rst_data", {7'b0, data_out}, 8'd0);
            chk("rst_ready", {7'b0, ready_out}, 8'd0);
            chk("rst_active", {7'b0, active_out}, 8'd0);
        end
        reset_L = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            step();
            chk("pre_data", {7'b0, data_out}, {7'b0, sym[7 - (c - 1) % 8]});
            chk("pre_active", {7'b0, active_out}, 8'd0);
            chk("pre_ready", {7'b0, ready_out}, {7'b0, c == 32});
        end
    endtask

    task automatic symbol(input vec_t v);
        chk("sym_ready", {7'b0, ready_out}, 8'd1);
        valid_in = v.valid;
        data_in  = v.data;
        for (int i = 7; i >= 0; i--) sb.push_back('{v.exp_sym[i], v.exp_act});
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            step();
            valid_in = 1'b0;
            data_in  = 8'($urandom);
            e = sb.pop_front();
            chk("sym_data", {7'b0, data_out}, {7'b0, e.bit_v});
            chk("sym_active", {7'b0, active_out}, {7'b0, e.act});
            chk("sym_mid_ready", {7'b0, ready_out}, {7'b0, i == 7});
        end
    endtask

    initial begin
        vecs = '{
            '{1'b1, 8'hA5, 8'hA5, 1'b1},
            '{1'b0, 8'h5A, BC,    1'b0},
            '{1'b1, 8'h00, 8'h00, 1'b1},
            '{1'b1, 8'hFF, 8'hFF, 1'b1},
            '{1'b0, 8'h77, BC,    1'b0},
            '{1'b1, 8'h81, 8'h81, 1'b1},
            '{1'b1, 8'h3C, 8'h3C, 1'b1},
            '{1'b0, 8'hC3, BC,    1'b0}
        };
        preamble(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) symbol(vecs[i]);
        // valid held high through the preamble must be ignored until the first ready
        preamble(1'b1, 8'h3C);
        symbol('{1'b1, 8'h3C, 8'h3C, 1'b1});
        symbol('{1'b0, 8'h00, BC, 1'b0});
        // reset while bit 4 of 0xF0 is on the line
        preamble(1'b0, 8'h00);
        w = 8'hF0;
        valid_in = 1'b1;
        data_in  = w;
        for (int b = 7; b >= 4; b--) begin
            step();
            valid_in = 1'b0;
            chk("mid_data", {7'b0, data_out}, {7'b0, w[b]});
            chk("mid_active", {7'b0, active_out}, 8'd1);
        end
        reset_L = 1'b0;
        step();
        chk("abort_data", {7'b0, data_out}, 8'd0);
        chk("abort_active", {7'b0, active_out}, 8'd0);
        chk("abort_ready", {7'b0, ready_out}, 8'd0);
        preamble(1'b0, 8'h00);
        symbol('{1'b1, 8'hC3, 8'hC3, 1'b1});
        symbol('{1'b0, 8'h00, BC, 1'b0});
`ifdef PS_BC_COUNTER_EN
        valid_in = 1'b0;
        reset_L  = 1'b0;
        step();
        chk("bc_reset", {5'b0, bc_counter_out}, 8'd0);
        reset_L = 1'b1;
        for (int c = 1; c <= 96; c++) begin
            step();
            chk("bc_count", {5'b0, bc_counter_out}, 8'(c >= 49 ? 7 : (c - 1) / 8 + 1));
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
